// File: rtl/audio_mixer.sv
// rtl/audio_mixer.sv - sequential NUM_CH-voice PCM mixer with attenuation and saturation
// Optional peak meter: define AUDIO_MIXER_PEAK_EN.
module audio_mixer #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 32
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_samples,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH*3-1:0]          ch_atten,
    input  logic [2:0]                   master_shift,
    output logic [SAMPLE_W-1:0]          mix_down,
    output logic                         mix_valid,
    output logic                         busy,
    output logic                         overrun
`ifdef AUDIO_MIXER_PEAK_EN
    ,
    output logic [SAMPLE_W-1:0]          peak
`endif
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SAT
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [NUM_CH*SAMPLE_W-1:0]    snap_samples;
    logic [NUM_CH-1:0]             snap_enable;
    logic [NUM_CH*3-1:0]           snap_atten;
    logic [2:0]                    snap_shift;
    logic signed [ACC_W-1:0]       acc;
    logic [IDX_W-1:0]              idx;

    logic signed [SAMPLE_W-1:0]    cur_sample;
    logic signed [SAMPLE_W-1:0]    cur_shifted;
    logic signed [ACC_W-1:0]       term;
    logic signed [ACC_W-1:0]       acc_shifted;
    logic [SAMPLE_W-1:0]           sat_result;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (sample_tick) state_next = S_ACCUM;
            S_ACCUM: if (idx == IDX_W'(NUM_CH-1)) state_next = S_SAT;
            S_SAT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Per-channel term: attenuate in sample width, then sign-extend into the accumulator.
    always_comb begin
        cur_sample  = snap_samples[idx*SAMPLE_W +: SAMPLE_W];
        cur_shifted = cur_sample >>> snap_atten[idx*3 +: 3];
        term        = '0;
        if (snap_enable[idx]) begin
            term = {{(ACC_W-SAMPLE_W){cur_shifted[SAMPLE_W-1]}}, cur_shifted};
        end
    end

    always_comb begin
        acc_shifted = acc >>> snap_shift;
        sat_result  = acc_shifted[SAMPLE_W-1:0];
        if (acc_shifted > SAT_MAX) begin
            sat_result = SAT_MAX[SAMPLE_W-1:0];
        end else if (acc_shifted < SAT_MIN) begin
            sat_result = SAT_MIN[SAMPLE_W-1:0];
        end
    end

`ifdef AUDIO_MIXER_PEAK_EN
    logic [SAMPLE_W-1:0] sat_mag;

    // The most negative value has no positive twin, so its magnitude pins at full scale.
    always_comb begin
        sat_mag = sat_result;
        if (sat_result[SAMPLE_W-1]) begin
            if (sat_result == SAT_MIN[SAMPLE_W-1:0]) begin
                sat_mag = SAT_MAX[SAMPLE_W-1:0];
            end else begin
                sat_mag = -sat_result;
            end
        end
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            snap_samples <= '0;
            snap_enable  <= '0;
            snap_atten   <= '0;
            snap_shift   <= '0;
            acc          <= '0;
            idx          <= '0;
            mix_down     <= '0;
            mix_valid    <= 1'b0;
            overrun      <= 1'b0;
`ifdef AUDIO_MIXER_PEAK_EN
            peak         <= '0;
`endif
        end else begin
            mix_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sample_tick) begin
                        snap_samples <= ch_samples;
                        snap_enable  <= ch_enable;
                        snap_atten   <= ch_atten;
                        snap_shift   <= master_shift;
                        acc          <= '0;
                        idx          <= '0;
`ifdef AUDIO_MIXER_PEAK_EN
                        if (master_shift == 3'd7 && ch_enable == '0) begin
                            peak <= '0;
                        end
`endif
                    end
                end
                S_ACCUM: begin
                    acc <= acc + term;
                    idx <= idx + 1'b1;
                    if (sample_tick) overrun <= 1'b1;
                end
                S_SAT: begin
                    mix_down  <= sat_result;
                    mix_valid <= 1'b1;
`ifdef AUDIO_MIXER_PEAK_EN
                    if (sat_mag > peak) peak <= sat_mag;
`endif
                    if (sample_tick) overrun <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mixer.sv
// tb/tb_audio_mixer.sv - self-checking bench for audio_mixer (vector table, random vs model, corner sequences)
module tb_audio_mixer;

    logic         clk;
    logic         reset;
    logic         sample_tick;
    logic [127:0] ch_samples;
    logic [3:0]   ch_enable;
    logic [11:0]  ch_atten;
    logic [2:0]   master_shift;
    logic [31:0]  mix_down;
    logic         mix_valid;
    logic         busy;
    logic         overrun;
`ifdef AUDIO_MIXER_PEAK_EN
    logic [31:0]  peak;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    audio_mixer #(.NUM_CH(4), .SAMPLE_W(32)) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .ch_samples   (ch_samples),
        .ch_enable    (ch_enable),
        .ch_atten     (ch_atten),
        .master_shift (master_shift),
        .mix_down     (mix_down),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .overrun      (overrun)
`ifdef AUDIO_MIXER_PEAK_EN
        ,
        .peak         (peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] s;
        logic [3:0]   en;
        logic [11:0]  at;
        logic [2:0]   sh;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: sign-extended integer sum of attenuated voices, master shift, clamp.
    function automatic logic [31:0] model(input logic [127:0] s, input logic [3:0] en,
                                          input logic [11:0] at, input logic [2:0] sh);
        longint acc = 0;
        for (int k = 0; k < 4; k++) begin
            if (en[k]) begin
                int     raw = s[k*32 +: 32];
                longint v   = raw;
                acc += v >>> at[k*3 +: 3];
            end
        end
        acc = acc >>> sh;
        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        return acc[31:0];
    endfunction

    task automatic scramble_inputs();
        ch_samples   = {$urandom, $urandom, $urandom, $urandom};
        ch_enable    = 4'($urandom);
        ch_atten     = 12'($urandom);
        master_shift = 3'($urandom);
    endtask

    // Tick in cycle 0, then scramble inputs and watch cycles 1..8.
    task automatic do_mix(input string name, input logic [127:0] s, input logic [3:0] en,
                          input logic [11:0] at, input logic [2:0] sh, input logic [31:0] exp);
        int vcount = 0;
        int vcyc   = -1;
        int busy_bad = 0;
        logic [31:0] got = '0;
        @(negedge clk);
        ch_samples = s; ch_enable = en; ch_atten = at; master_shift = sh;
        sample_tick = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            scramble_inputs();
            if (busy !== (c <= 5)) busy_bad++;
            if (mix_valid) begin
                vcount++;
                vcyc = c;
                got  = mix_down;
            end
        end
        check({name, " valid_count"}, vcount, 1);
        check({name, " valid_cycle"}, vcyc, 6);
        check({name, " mix_down"}, got, exp);
        check({name, " busy_window"}, busy_bad, 0);
        check({name, " held"}, mix_down, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{{32'd400, 32'd300, 32'd200, 32'd100}, 4'b1111, 12'h000, 3'd0, 32'd1000};
        vecs[1] = '{{4{32'h7FFFFFFF}}, 4'b1111, 12'h000, 3'd0, 32'h7FFFFFFF};
        vecs[2] = '{{4{32'h80000000}}, 4'b1111, 12'h000, 3'd0, 32'h80000000};
        vecs[3] = '{{32'd55, 32'd66, 32'd77, 32'hFFFFFC00}, 4'b0001, 12'h002, 3'd1, 32'hFFFFFF80};
        vecs[4] = '{{32'd9, 32'd8, 32'd7, 32'd6}, 4'b0000, 12'hFFF, 3'd0, 32'd0};
        vecs[5] = '{{4{32'h7FFFFFFF}}, 4'b1111, 12'h000, 3'd2, 32'h7FFFFFFF};
        vecs[6] = '{{32'd1, 32'd1, 32'd5, 32'hFFFFFFF9}, 4'b0011, 12'h001, 3'd0, 32'd1};

        reset = 1'b1;
        sample_tick = 1'($urandom);
        scramble_inputs();
        @(negedge clk);
        sample_tick = 1'($urandom);
        scramble_inputs();
        @(negedge clk);
        check("reset mix_down", mix_down, 0);
        check("reset mix_valid", mix_valid, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);
        reset = 1'b0;
        sample_tick = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_mix($sformatf("vec%0d", i), vecs[i].s, vecs[i].en, vecs[i].at, vecs[i].sh, vecs[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            logic [127:0] s;
            logic [3:0]   en;
            logic [11:0]  at;
            logic [2:0]   sh;
            s  = {$urandom, $urandom, $urandom, $urandom};
            if (i % 4 == 0) s = s | {4{32'h7F000000}};
            en = 4'($urandom);
            at = 12'($urandom);
            sh = 3'($urandom);
            do_mix($sformatf("rand%0d", i), s, en, at, sh, model(s, en, at, sh));
        end

        check("overrun before", overrun, 0);

        // Overrun: ticks at 0 and 3 (ignored), back-to-back tick at 6.
        begin
            int vcount = 0;
            int ov_bad = 0;
            logic [127:0] s2;
            logic [31:0]  exp2;
            s2   = {$urandom, $urandom, $urandom, $urandom};
            exp2 = model(s2, 4'b1011, 12'h123, 3'd1);
            @(negedge clk);
            ch_samples = {32'd400, 32'd300, 32'd200, 32'd100};
            ch_enable = 4'b1111; ch_atten = '0; master_shift = 3'd0;
            sample_tick = 1'b1;
            for (int c = 1; c <= 14; c++) begin
                @(negedge clk);
                sample_tick = 1'b0;
                scramble_inputs();
                if (c == 3) sample_tick = 1'b1;
                if (c == 6) begin
                    ch_samples = s2; ch_enable = 4'b1011; ch_atten = 12'h123; master_shift = 3'd1;
                    sample_tick = 1'b1;
                end
                if (overrun !== (c >= 4)) ov_bad++;
                if (mix_valid) begin
                    vcount++;
                    if (c == 6) check("overrun first sum", mix_down, 32'd1000);
                    else if (c == 12) check("backtoback sum", mix_down, exp2);
                    else check("unexpected valid cycle", c, 0);
                end
            end
            check("overrun flag timing", ov_bad, 0);
            check("overrun valid count", vcount, 2);
        end

        // Reset in cycle 3 aborts the mix.
        begin
            int vcount = 0;
            @(negedge clk);
            ch_samples = {32'd4, 32'd3, 32'd2, 32'd1};
            ch_enable = 4'b1111; ch_atten = '0; master_shift = 3'd0;
            sample_tick = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                sample_tick = 1'b0;
                reset = (c == 3);
                if (mix_valid) vcount++;
            end
            check("abort valid count", vcount, 0);
            check("abort mix_down", mix_down, 0);
            check("abort overrun", overrun, 0);
            check("abort busy", busy, 0);
        end
        do_mix("after_abort", {32'd400, 32'd300, 32'd200, 32'd100}, 4'b1111, 12'h000, 3'd0, 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
- Mixes NUM_CH signed PCM voice streams into the single 32-bit `mix_down` word consumed by the audio output stage.
- Mixing is sequential, one channel per clock, and starts on `sample_tick`. The top level drives `sample_tick` from the codec's write strobe.
- Per-channel enable and attenuation, a master attenuation, then saturation to the output width.
- The result is held stable between ticks. `mix_valid` pulses once per completed mix.

Parameters:
- NUM_CH, 4, number of input voices (2..8).
- SAMPLE_W, 32, width of each input sample and of `mix_down`. Signed, two's complement.

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_tick  input  1  request for a new mix; sampled every cycle.
- ch_samples  input  NUM_CH*SAMPLE_W  flattened signed samples; channel k = bits [k*SAMPLE_W +: SAMPLE_W].
- ch_enable  input  NUM_CH  1 = channel contributes; 0 = channel treated as zero.
- ch_atten  input  NUM_CH*3  per-channel arithmetic right shift, 0..7; channel k = bits [k*3 +: 3].
- master_shift  input  3  arithmetic right shift applied to the sum, 0..7.
- mix_down  output  SAMPLE_W  saturated mix, registered.
- mix_valid  output  1  one-cycle pulse when `mix_down` updates.
- busy  output  1  high while a mix is in progress.
- overrun  output  1  sticky flag: a tick arrived while busy.
- peak  output  SAMPLE_W  present only with AUDIO_MIXER_PEAK_EN.

Behaviour:
- Reset (synchronous, active-high; polarity and synchronicity fixed):
  - State goes to IDLE.
  - `mix_down`, `mix_valid`, `busy`, `overrun` and `peak` all go to 0.
  - Accumulator, channel index and snapshot registers are cleared.
- State machine IDLE -> ACCUM -> SAT -> IDLE:
  - IDLE: on `sample_tick`=1, snapshot `ch_samples`, `ch_enable`, `ch_atten` and `master_shift`. Clear the accumulator, set idx=0, go to ACCUM. Input changes after the snapshot are ignored until the next accepted tick.
  - ACCUM: add term(idx) to the accumulator, where term = enable ? (sample >>> atten) : 0, sign-extended. Increment idx. After idx = NUM_CH-1, go to SAT. Occupies exactly NUM_CH cycles.
  - SAT: compute s = acc >>> master_shift, then clamp to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. Load `mix_down` with the result, set `mix_valid`=1 for one cycle, go to IDLE.
- Accumulator width is SAMPLE_W + clog2(NUM_CH) + 1. No intermediate wrap is permitted.
- Latency, with the tick accepted in cycle 0:
  - New `mix_down` and the `mix_valid` pulse are visible in cycle NUM_CH+2 (cycle 6 for the default).
  - `mix_down` holds its value until the next completed mix.
- `busy` = 1 in cycles 1..NUM_CH+1, i.e. whenever the state is ACCUM or SAT.
- Tick while ACCUM or SAT:
  - The tick is ignored and `overrun` is set.
  - The in-flight mix completes unchanged.
  - `overrun` clears only on reset.
- A tick coincident with `mix_valid`=1 is accepted, since the state is already IDLE; this gives back-to-back mixes.
- Reset mid-ACCUM or mid-SAT aborts the mix: no `mix_valid`, and `mix_down`=0.
- All channels disabled gives `mix_down`=0 with a normal `mix_valid` pulse.

Optional Feature:
- Macro: AUDIO_MIXER_PEAK_EN.
- Defined:
  - The `peak` port exists.
  - On each `mix_valid`, `peak` <= max(`peak`, |`mix_down`|). The magnitude of the most negative value saturates to 2^(SAMPLE_W-1)-1.
  - `peak` clears on reset, or on a tick in IDLE while `master_shift`=7 and `ch_enable`=0 (meter clear).
- Undefined: no `peak` port, no peak register. All other behaviour is identical.

Test Plan:
- Reset: assert `reset` 2 cycles with random inputs -> `mix_down`=0, `mix_valid`=0, `busy`=0, `overrun`=0.
- Basic sum:
  - Stimulus: samples 100, 200, 300, 400; enable=4'b1111; atten=0; shift=0; tick at cycle 0.
  - Required: `busy` high in cycles 1..5; `mix_down`=1000 and a single `mix_valid` pulse in cycle 6.
- Saturation:
  - All four channels 0x7FFFFFFF -> `mix_down`=0x7FFFFFFF.
  - All four channels 0x80000000 -> `mix_down`=0x80000000.
- Shifts:
  - Stimulus: ch0=-1024 with atten=2, channels 1-3 disabled, shift=1.
  - Required: `mix_down`=-128 (0xFFFFFF80).
- Overrun:
  - Stimulus: tick at cycle 0 and cycle 3.
  - Required: `overrun`=1 from cycle 4; exactly one `mix_valid`, in cycle 6, with the correct sum.
  - Follow-up: a tick at cycle 6 is accepted; next `mix_valid` in cycle 12.
- Reset mid-mix:
  - Stimulus: tick, then reset in cycle 3.
  - Required: no `mix_valid`; `mix_down`=0.
  - Follow-up: a subsequent tick produces a correct result.
